// File: rtl/f2i_pipe.sv
// ----------------------------------------------------------------------------
// f2i_pipe
//   Pipelined float-to-integer converter with a valid/ready stream interface.
//   Converts a {sign, exp, frac} binary float into a signed or unsigned
//   INT_W-bit integer using one of four rounding modes. The fixed latency is
//   two stages, and the converter accepts one conversion per cycle.
//
//   Stage 1 decodes the float and aligns the significand. It produces the
//   integer magnitude M, a guard bit G and a sticky bit S. Stage 2 rounds,
//   range-checks, saturates or negates the value, and then registers it.
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   in_valid      input word valid
//   in_ready      converter accepts the input this cycle
//   in_a          float {sign, exp[EXP_W], frac[FRAC_W]}
//   in_rmode      00 toward zero, 01 nearest-even, 10 floor, 11 ceil
//   in_unsigned   1 = unsigned result range
//   out_valid     result valid
//   out_ready     downstream accepts the result
//   out_d         integer result
//   out_p_lost    inexact result
//   out_denorm    input was a denormal
//   out_invalid   NaN, infinity or out of range
// ----------------------------------------------------------------------------
module f2i_pipe #(
   parameter int EXP_W  = 8,
   parameter int FRAC_W = 23,
   parameter int INT_W  = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [EXP_W+FRAC_W:0]   in_a,
   input  logic [1:0]              in_rmode,
   input  logic                    in_unsigned,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [INT_W-1:0]        out_d,
   output logic                    out_p_lost,
   output logic                    out_denorm,
   output logic                    out_invalid
);

   localparam int BIAS = (1 << (EXP_W - 1)) - 1;
   // The aligned significand is wide enough for {1,frac} << (INT_W-1).
   localparam int SW   = FRAC_W + 1 + INT_W;

   localparam logic [INT_W:0]   SMAX_MAG = {2'b00, {(INT_W-1){1'b1}}};
   localparam logic [INT_W:0]   SMIN_MAG = {2'b01, {(INT_W-1){1'b0}}};
   localparam logic [INT_W-1:0] ONE_I    = {{(INT_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      RM_RTZ   = 2'b00,
      RM_RNE   = 2'b01,
      RM_FLOOR = 2'b10,
      RM_CEIL  = 2'b11
   } rmode_e;

   // ---------------- handshake ----------------
   logic v1_q, v2_q;
   logic s1_load, s2_load;

   assign s2_load   = ~v2_q | out_ready;
   assign s1_load   = ~v1_q | s2_load;
   assign in_ready  = s1_load;
   assign out_valid = v2_q;

   // ---------------- stage 1: decode and align ----------------
   logic               a_sign;
   logic [EXP_W-1:0]   a_exp;
   logic [FRAC_W-1:0]  a_frac;
   logic               exp_max, exp_zero, frac_nz;

   assign a_sign   = in_a[EXP_W+FRAC_W];
   assign a_exp    = in_a[EXP_W+FRAC_W-1:FRAC_W];
   assign a_frac   = in_a[FRAC_W-1:0];
   assign exp_max  = &a_exp;
   assign exp_zero = ~|a_exp;
   assign frac_nz  = |a_frac;

   logic [INT_W:0]    m1_d, m1_q;
   logic              g1_d, g1_q;
   logic              s1_d, s1_q;
   logic              nan1_d, nan1_q;
   logic              sat1_d, sat1_q;
   logic              dn1_d, dn1_q;
   logic              sign1_q;
   rmode_e            rm1_q;
   logic              uns1_q;
   logic [SW-1:0]     shifted;
   logic [EXP_W-1:0]  sh_amt;

   always_comb begin
      m1_d    = '0;
      g1_d    = 1'b0;
      s1_d    = 1'b0;
      nan1_d  = 1'b0;
      sat1_d  = 1'b0;
      dn1_d   = 1'b0;
      shifted = '0;
      sh_amt  = '0;
      if (exp_max) begin
         if (frac_nz) nan1_d = 1'b1;
         else         sat1_d = 1'b1;
      end else if (exp_zero) begin
         // A denormal is nonzero but far below 1/2: it only sets sticky.
         if (frac_nz) begin
            dn1_d = 1'b1;
            s1_d  = 1'b1;
         end
      end else if (int'(a_exp) >= BIAS + INT_W) begin
         sat1_d = 1'b1;
      end else if (int'(a_exp) >= BIAS) begin
         sh_amt  = a_exp - EXP_W'(BIAS);
         shifted = {{INT_W{1'b0}}, 1'b1, a_frac} << sh_amt;
         m1_d    = shifted[SW-1:FRAC_W];
         g1_d    = shifted[FRAC_W-1];
         s1_d    = |shifted[FRAC_W-2:0];
      end else if (int'(a_exp) == BIAS - 1) begin
         g1_d = 1'b1;
         s1_d = frac_nz;
      end else begin
         s1_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q    <= 1'b0;
         m1_q    <= '0;
         g1_q    <= 1'b0;
         s1_q    <= 1'b0;
         nan1_q  <= 1'b0;
         sat1_q  <= 1'b0;
         dn1_q   <= 1'b0;
         sign1_q <= 1'b0;
         rm1_q   <= RM_RTZ;
         uns1_q  <= 1'b0;
      end else if (s1_load) begin
         v1_q    <= in_valid;
         m1_q    <= m1_d;
         g1_q    <= g1_d;
         s1_q    <= s1_d;
         nan1_q  <= nan1_d;
         sat1_q  <= sat1_d;
         dn1_q   <= dn1_d;
         sign1_q <= a_sign;
         rm1_q   <= rmode_e'(in_rmode);
         uns1_q  <= in_unsigned;
      end
   end

   // ---------------- stage 2: round, range-check, negate ----------------
   logic              lost, inc, in_range;
   logic [INT_W:0]    mr;
   logic [INT_W-1:0]  sat_max, sat_min;
   logic [INT_W-1:0]  d2_d, d2_q;
   logic              pl2_d, pl2_q;
   logic              dn2_d, dn2_q;
   logic              inv2_d, inv2_q;

   always_comb begin
      lost = g1_q | s1_q;
      inc  = 1'b0;
      case (rm1_q)
         RM_RTZ:   inc = 1'b0;
         RM_RNE:   inc = g1_q & (s1_q | m1_q[0]);
         RM_FLOOR: inc = sign1_q & lost;
         RM_CEIL:  inc = ~sign1_q & lost;
      endcase
      // M < 2^INT_W for any in-range exponent, so the increment cannot wrap.
      mr = m1_q + {{INT_W{1'b0}}, inc};

      if (uns1_q) begin
         sat_max  = '1;
         sat_min  = '0;
         in_range = sign1_q ? (mr == '0) : ~mr[INT_W];
      end else begin
         sat_max  = {1'b0, {(INT_W-1){1'b1}}};
         sat_min  = {1'b1, {(INT_W-1){1'b0}}};
         in_range = sign1_q ? (mr <= SMIN_MAG) : (mr <= SMAX_MAG);
      end

      d2_d   = '0;
      pl2_d  = 1'b0;
      inv2_d = 1'b1;
      dn2_d  = dn1_q;
      if (nan1_q) begin
         d2_d = '0;
      end else if (sat1_q || !in_range) begin
         d2_d = sign1_q ? sat_min : sat_max;
      end else begin
         inv2_d = 1'b0;
         pl2_d  = lost;
         d2_d   = sign1_q ? (~mr[INT_W-1:0] + ONE_I) : mr[INT_W-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v2_q   <= 1'b0;
         d2_q   <= '0;
         pl2_q  <= 1'b0;
         dn2_q  <= 1'b0;
         inv2_q <= 1'b0;
      end else if (s2_load) begin
         v2_q <= v1_q;
         if (v1_q) begin
            d2_q   <= d2_d;
            pl2_q  <= pl2_d;
            dn2_q  <= dn2_d;
            inv2_q <= inv2_d;
         end
      end
   end

   assign out_d       = d2_q;
   assign out_p_lost  = pl2_q;
   assign out_denorm  = dn2_q;
   assign out_invalid = inv2_q;

endmodule

// File: tb/tb_f2i_pipe.sv
// ----------------------------------------------------------------------------
// tb_f2i_pipe
//   Self-checking bench for f2i_pipe at default widths (8/23 -> 32).
//   Table vectors are driven through the stream interface. A scoreboard queue
//   holds the expected results and a monitor checks every output transfer and
//   stall stability. Hand sequences cover latency, streaming with backpressure
//   and a mid-stream reset.
// ----------------------------------------------------------------------------
module tb_f2i_pipe;

   localparam int EXP_W  = 8;
   localparam int FRAC_W = 23;
   localparam int INT_W  = 32;
   localparam int NV     = 26;

   logic              clk;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       in_a;
   logic [1:0]        in_rmode;
   logic              in_unsigned;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_d;
   logic              out_p_lost;
   logic              out_denorm;
   logic              out_invalid;

   f2i_pipe #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .INT_W(INT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_a        (in_a),
      .in_rmode    (in_rmode),
      .in_unsigned (in_unsigned),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_d       (out_d),
      .out_p_lost  (out_p_lost),
      .out_denorm  (out_denorm),
      .out_invalid (out_invalid)
   );

   typedef struct {
      logic [31:0] a;
      logic [1:0]  rm;
      logic        uns;
      logic [31:0] d;
      logic        pl;
      logic        dn;
      logic        inv;
   } vec_t;

   typedef struct packed {
      logic [31:0] d;
      logic        pl;
      logic        dn;
      logic        inv;
   } res_t;

   res_t sb_q[$];
   vec_t vt[NV];
   int   total;
   int   bad;
   int   pat[6];
   logic pat_en;
   int   pidx;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- output monitor ----------------
   res_t held;
   logic held_v;
   res_t cur;
   res_t expv;

   initial held_v = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         held_v = 1'b0;
      end else begin
         cur = '{out_d, out_p_lost, out_denorm, out_invalid};
         if (held_v) begin
            total++;
            if (!out_valid || cur != held) begin
               bad++;
               $display("FAIL stall_hold: got v=%0b %h/%0b%0b%0b required v=1 %h/%0b%0b%0b",
                        out_valid, cur.d, cur.pl, cur.dn, cur.inv,
                        held.d, held.pl, held.dn, held.inv);
            end
         end
         held_v = out_valid && !out_ready;
         held   = cur;
         if (out_valid && out_ready) begin
            total++;
            if (sb_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_output: got d=%h with no result pending", out_d);
            end else begin
               expv = sb_q.pop_front();
               if (cur != expv) begin
                  bad++;
                  $display("FAIL result: got d=%h pl=%0b dn=%0b inv=%0b required d=%h pl=%0b dn=%0b inv=%0b",
                           cur.d, cur.pl, cur.dn, cur.inv,
                           expv.d, expv.pl, expv.dn, expv.inv);
               end
            end
         end
      end
   end

   // ---------------- backpressure pattern ----------------
   initial begin
      pat = '{1, 0, 1, 1, 0, 0};
      forever begin
         @(posedge clk);
         #1;
         if (pat_en) begin
            out_ready = (pat[pidx % 6] != 0);
            pidx++;
         end
      end
   end

   task automatic send(input vec_t v);
      int n;
      n = 0;
      in_valid    = 1'b1;
      in_a        = v.a;
      in_rmode    = v.rm;
      in_unsigned = v.uns;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         total++;
         bad++;
         $display("FAIL send_timeout: got in_ready=0 required 1 within 100 cycles");
      end else begin
         sb_q.push_back('{v.d, v.pl, v.dn, v.inv});
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      if (sb_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: got %0d pending required 0", sb_q.size());
         sb_q.delete();
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      //           a            rm     uns   d             pl    dn    inv
      vt[0]  = '{32'h3FC00000, 2'd0, 1'b0, 32'h00000001, 1'b1, 1'b0, 1'b0};
      vt[1]  = '{32'h3FC00000, 2'd1, 1'b0, 32'h00000002, 1'b1, 1'b0, 1'b0};
      vt[2]  = '{32'h3FC00000, 2'd2, 1'b0, 32'h00000001, 1'b1, 1'b0, 1'b0};
      vt[3]  = '{32'h3FC00000, 2'd3, 1'b0, 32'h00000002, 1'b1, 1'b0, 1'b0};
      vt[4]  = '{32'h40200000, 2'd1, 1'b0, 32'h00000002, 1'b1, 1'b0, 1'b0};
      vt[5]  = '{32'hC0200000, 2'd1, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0};
      vt[6]  = '{32'h40400000, 2'd1, 1'b0, 32'h00000003, 1'b0, 1'b0, 1'b0};
      vt[7]  = '{32'h4F000000, 2'd0, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1};
      vt[8]  = '{32'hCF000000, 2'd0, 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b0};
      vt[9]  = '{32'h4F000000, 2'd0, 1'b1, 32'h80000000, 1'b0, 1'b0, 1'b0};
      vt[10] = '{32'hBF800000, 2'd0, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b1};
      vt[11] = '{32'hBE800000, 2'd0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b0};
      vt[12] = '{32'h7F800000, 2'd0, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1};
      vt[13] = '{32'hFF800000, 2'd0, 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b1};
      vt[14] = '{32'h7FC00000, 2'd0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1};
      vt[15] = '{32'h80000000, 2'd0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0};
      vt[16] = '{32'h00000001, 2'd3, 1'b0, 32'h00000001, 1'b1, 1'b1, 1'b0};
      vt[17] = '{32'h00000001, 2'd1, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0};
      vt[18] = '{32'h4EFFFFFF, 2'd0, 1'b0, 32'h7FFFFF80, 1'b0, 1'b0, 1'b0};
      vt[19] = '{32'hBE800000, 2'd2, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
      vt[20] = '{32'h3F000000, 2'd1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0};
      vt[21] = '{32'h3F400000, 2'd1, 1'b0, 32'h00000001, 1'b1, 1'b0, 1'b0};
      vt[22] = '{32'hBFC00000, 2'd2, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0};
      vt[23] = '{32'h4F800000, 2'd0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1};
      vt[24] = '{32'h80000001, 2'd2, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0};
      vt[25] = '{32'h80000001, 2'd2, 1'b1, 32'h00000000, 1'b0, 1'b1, 1'b1};

      total       = 0;
      bad         = 0;
      pat_en      = 1'b0;
      pidx        = 0;
      rst         = 1'b1;
      in_valid    = 1'b0;
      in_a        = '0;
      in_rmode    = '0;
      in_unsigned = 1'b0;
      out_ready   = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (out_valid !== 1'b0 || out_d !== 32'h0 || out_p_lost !== 1'b0 ||
          out_denorm !== 1'b0 || out_invalid !== 1'b0) begin
         bad++;
         $display("FAIL reset_state: got v=%0b d=%h flags=%0b%0b%0b required all zero",
                  out_valid, out_d, out_p_lost, out_denorm, out_invalid);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Table vectors, one at a time
      out_ready = 1'b1;
      for (int i = 0; i < NV; i++) send(vt[i]);
      drain();

      // Latency: accept edge, then out_valid after the following edge
      in_valid    = 1'b1;
      in_a        = 32'h40400000;
      in_rmode    = 2'd1;
      in_unsigned = 1'b0;
      @(negedge clk);
      sb_q.push_back('{32'h00000003, 1'b0, 1'b0, 1'b0});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL latency_early: got out_valid=%0b required 0", out_valid);
      end
      @(posedge clk);
      #1;
      total++;
      if (out_valid !== 1'b1) begin
         bad++;
         $display("FAIL latency_2: got out_valid=%0b required 1", out_valid);
      end
      drain();

      // Streaming, back-to-back with the out_ready pattern 1,0,1,1,0,0
      pidx   = 0;
      pat_en = 1'b1;
      for (int i = 0; i < 16; i++) send(vt[(i * 7) % NV]);
      drain();
      pat_en    = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;

      // Mid-stream reset: the pipeline holds data, then is flushed
      out_ready = 1'b0;
      send(vt[0]);
      send(vt[6]);
      in_valid    = 1'b1;
      in_a        = vt[9].a;
      in_rmode    = vt[9].rm;
      in_unsigned = vt[9].uns;
      #2;
      rst = 1'b1;
      #1;
      total++;
      if (out_valid !== 1'b0 || out_d !== 32'h0 || out_invalid !== 1'b0 ||
          out_p_lost !== 1'b0 || out_denorm !== 1'b0) begin
         bad++;
         $display("FAIL reset_async: got v=%0b d=%h required v=0 d=0 flags 0",
                  out_valid, out_d);
      end
      sb_q.delete();
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_in_ready: got %0b required 1", in_ready);
      end
      out_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_no_stale: got out_valid=%0b required 0", out_valid);
      end

      // A conversion after the reset still works
      send(vt[21]);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish required finish within 200000");
      $fatal(1, "timeout");
   end

endmodule
